// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Purpose:
//   Slave end of the memory-stage mm_* port of the pipelined RV64 core.
//   It accepts read and write requests and commits byte-lane writes into an
//   internal synchronous RAM. It answers every request with a one-cycle
//   mm_rvalid pulse. Reads return the full aligned doubleword. Write acks
//   carry no data. Illegal requests are answered with mm_err and leave the
//   RAM untouched.
//
// Configuration macro:
//   DMEM_WAIT_EN - when defined, adds a WAIT state of WAIT_CYCLES stall
//                  cycles and makes the responder single-outstanding.
//                  When undefined, latency is a fixed one cycle and one
//                  request per cycle is accepted.
//
// Parameters:
//   ADDR_BASE    - physical byte address of RAM word 0
//   DEPTH_WORDS  - RAM depth in 64-bit doublewords (power of two)
//   WAIT_CYCLES  - stall cycles per request (1..15), DMEM_WAIT_EN only
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   rstn       in   1   synchronous active-low reset
//   mm_addr    in  64   request byte address
//   mm_wdata   in  64   write data, low 8*mm_wlen bits significant
//   mm_wlen    in   4   write size in bytes (1, 2, 4, 8)
//   mm_wen     in   1   write request
//   mm_ren     in   1   read request
//   mm_ready   out  1   a request can be accepted this cycle
//   mm_rvalid  out  1   one-cycle response pulse (read data or write ack)
//   mm_rdata   out 64   read data, zero whenever mm_rvalid is low
//   mm_err     out  1   response error flag, zero whenever mm_rvalid is low
//
// The RAM array is named 'mem' so benches can preload it hierarchically.
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] mm_addr,
    input  logic [63:0] mm_wdata,
    input  logic [3:0]  mm_wlen,
    input  logic        mm_wen,
    input  logic        mm_ren,
    output logic        mm_ready,
    output logic        mm_rvalid,
    output logic [63:0] mm_rdata,
    output logic        mm_err
);

    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [63:0] WINDOW_BYTES = 64'(DEPTH_WORDS) << 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef DMEM_WAIT_EN
    localparam logic [1:0] ST_WAIT = 2'd1;
`endif

    logic [63:0]      mem [DEPTH_WORDS];

    logic [1:0]       state;
    logic [63:0]      rdata_q;
    logic             err_q;
`ifdef DMEM_WAIT_EN
    logic [3:0]       wait_cnt;
`endif

    logic [63:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             len_ok;
    logic             align_ok;
    logic [7:0]       len_mask;
    logic [7:0]       strobe;
    logic [63:0]      wdata_sh;
    logic             accept;
    logic             bad;
    logic             do_write;

    // Request decode: work out the word index, whether the request is legal,
    // and which byte lanes a write touches. The window check compares the
    // offset rather than ADDR_BASE+size so it cannot overflow near the top of
    // the 64-bit address space. A request presented while reset is low is not
    // accepted, so reset can never commit a stray write.
    always_comb begin
        offset   = mm_addr - ADDR_BASE;
        in_range = (mm_addr >= ADDR_BASE) && (offset < WINDOW_BYTES);
        idx      = offset[IDX_W+2:3];

        len_ok   = 1'b0;
        align_ok = 1'b0;
        len_mask = 8'h00;
        case (mm_wlen)
            4'd1: begin len_ok = 1'b1; align_ok = 1'b1;                  len_mask = 8'h01; end
            4'd2: begin len_ok = 1'b1; align_ok = ~mm_addr[0];           len_mask = 8'h03; end
            4'd4: begin len_ok = 1'b1; align_ok = (mm_addr[1:0] == 2'b0); len_mask = 8'h0F; end
            4'd8: begin len_ok = 1'b1; align_ok = (mm_addr[2:0] == 3'b0); len_mask = 8'hFF; end
            default: begin len_ok = 1'b0; align_ok = 1'b0; len_mask = 8'h00; end
        endcase

        strobe   = len_mask << mm_addr[2:0];
        wdata_sh = mm_wdata << {mm_addr[2:0], 3'b000};

        accept   = (mm_ren | mm_wen) & mm_ready & rstn;
        bad      = ~in_range
                 | (mm_ren & mm_wen)
                 | (mm_wen & (~len_ok | ~align_ok));
        do_write = accept & mm_wen & ~bad;
    end

    // Byte-lane RAM write, committed on the acceptance edge so a read
    // accepted one cycle later already sees the new bytes. The RAM is
    // deliberately not reset; its contents survive rstn.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 8; b++) begin
                if (strobe[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Response FSM. The response payload is captured at acceptance, so later
    // input changes cannot disturb it. Because mm_ready already blocks
    // acceptance in WAIT and (with wait states) RESP, capture can sit outside
    // the state case. Reset drops any pending response by returning to IDLE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
            if (accept) begin
                rdata_q <= (mm_ren & ~bad) ? mem[idx] : 64'd0;
                err_q   <= bad;
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef DMEM_WAIT_EN
                        state    <= ST_WAIT;
                        wait_cnt <= 4'(WAIT_CYCLES);
`else
                        state    <= ST_RESP;
`endif
                    end
                end
`ifdef DMEM_WAIT_EN
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
`else
                ST_RESP: begin
                    state <= accept ? ST_RESP : ST_IDLE;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs. Without wait states the responder is always ready and runs
    // fully pipelined; with them it only takes a request from IDLE.
    // rdata and err are forced to zero outside the response pulse.
`ifdef DMEM_WAIT_EN
    assign mm_ready = (state == ST_IDLE);
`else
    assign mm_ready = 1'b1;
`endif
    assign mm_rvalid = (state == ST_RESP);
    assign mm_rdata  = mm_rvalid ? rdata_q : 64'd0;
    assign mm_err    = mm_rvalid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. It preloads the RAM hierarchically,
// then issues writes, reads and illegal requests. Each response is compared
// against hand-computed values. Wait-state checks are compiled in when
// DMEM_WAIT_EN is defined. Otherwise the back-to-back pipelined checks run.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int          WAIT_CYCLES = 2;
    localparam logic [63:0] BASE        = 64'h8000_0000;
`ifdef DMEM_WAIT_EN
    localparam int          EXP_LAT     = 1 + WAIT_CYCLES;
`else
    localparam int          EXP_LAT     = 1;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [63:0] mm_addr;
    logic [63:0] mm_wdata;
    logic [3:0]  mm_wlen;
    logic        mm_wen;
    logic        mm_ren;
    logic        mm_ready;
    logic        mm_rvalid;
    logic [63:0] mm_rdata;
    logic        mm_err;

    int tests = 0;
    int fails = 0;

    dmem_responder #(
        .ADDR_BASE   (BASE),
        .DEPTH_WORDS (4096),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mm_addr   (mm_addr),
        .mm_wdata  (mm_wdata),
        .mm_wlen   (mm_wlen),
        .mm_wen    (mm_wen),
        .mm_ren    (mm_ren),
        .mm_ready  (mm_ready),
        .mm_rvalid (mm_rvalid),
        .mm_rdata  (mm_rdata),
        .mm_err    (mm_err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Drive one request onto the mm_* inputs.
    task automatic applyStimulus(input logic ren, input logic wen,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input logic [3:0] wlen);
        mm_ren   = ren;
        mm_wen   = wen;
        mm_addr  = addr;
        mm_wdata = wdata;
        mm_wlen  = wlen;
    endtask

    // Compare one observed value with its expected value and count it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait (bounded) for acceptance and for the response,
    // then check latency, error flag and optionally the data.
    task automatic doRequest(input string tag, input logic ren, input logic wen,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [3:0] wlen, input logic exp_err,
                             input logic check_data, input logic [63:0] exp_data);
        int n;
        int lat;
        applyStimulus(ren, wen, addr, wdata, wlen);
        n = 0;
        while (!mm_ready && n < 50) begin
            tick();
            n++;
        end
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
        lat = 1;
        while (!mm_rvalid && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput({tag, " rvalid"}, 64'(mm_rvalid), 64'd1);
        checkOutput({tag, " latency"}, 64'(lat), 64'(EXP_LAT));
        checkOutput({tag, " err"}, 64'(mm_err), 64'(exp_err));
        if (check_data) begin
            checkOutput({tag, " rdata"}, mm_rdata, exp_data);
        end
    endtask

    initial begin
        logic saw_valid;

        rstn = 1'b0;
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
        repeat (3) tick();
        checkOutput("reset ready", 64'(mm_ready), 64'd1);
        checkOutput("reset rvalid", 64'(mm_rvalid), 64'd0);
        checkOutput("reset rdata", mm_rdata, 64'd0);
        checkOutput("reset err", 64'(mm_err), 64'd0);

        dut.mem[0]    = 64'h1122_3344_5566_7788;
        dut.mem[2]    = 64'h0;
        dut.mem[4095] = 64'h0123_4567_89AB_CDEF;
        rstn = 1'b1;
        tick();

        // Byte and halfword writes into the preloaded word.
        doRequest("byte wr", 1'b0, 1'b1, BASE + 64'h3, 64'hAB, 4'd1, 1'b0, 1'b0, 64'd0);
        doRequest("byte rd", 1'b1, 1'b0, BASE, 64'd0, 4'd0, 1'b0, 1'b1, 64'h1122_3344_AB66_7788);
        doRequest("half wr", 1'b0, 1'b1, BASE + 64'h6, 64'hBEEF, 4'd2, 1'b0, 1'b0, 64'd0);
        doRequest("half rd", 1'b1, 1'b0, BASE, 64'd0, 4'd0, 1'b0, 1'b1, 64'hBEEF_3344_AB66_7788);

        // Window boundaries.
        doRequest("below base", 1'b1, 1'b0, 64'h7FFF_FFF8, 64'd0, 4'd0, 1'b1, 1'b1, 64'd0);
        doRequest("past end", 1'b1, 1'b0, 64'h8000_8000, 64'd0, 4'd0, 1'b1, 1'b1, 64'd0);
        doRequest("last word", 1'b1, 1'b0, 64'h8000_7FF8, 64'd0, 4'd0, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF);

        // Illegal writes leave the RAM untouched.
        doRequest("misalign wr", 1'b0, 1'b1, BASE + 64'h2, 64'hFFFF_FFFF, 4'd4, 1'b1, 1'b1, 64'd0);
        doRequest("wlen3 wr", 1'b0, 1'b1, BASE, 64'hFFFF_FFFF, 4'd3, 1'b1, 1'b1, 64'd0);
        doRequest("ren+wen", 1'b1, 1'b1, BASE, 64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b1, 1'b1, 64'd0);
        doRequest("after err rd", 1'b1, 1'b0, BASE, 64'd0, 4'd0, 1'b0, 1'b1, 64'hBEEF_3344_AB66_7788);

`ifdef DMEM_WAIT_EN
        doRequest("dword wr", 1'b0, 1'b1, BASE + 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 4'd8, 1'b0, 1'b0, 64'd0);
        tick();
`else
        // Back-to-back write then read of the same doubleword.
        tick();
        applyStimulus(1'b0, 1'b1, BASE + 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 4'd8);
        checkOutput("b2b ready T", 64'(mm_ready), 64'd1);
        tick();
        checkOutput("b2b ack rvalid", 64'(mm_rvalid), 64'd1);
        checkOutput("b2b ack err", 64'(mm_err), 64'd0);
        checkOutput("b2b ready T1", 64'(mm_ready), 64'd1);
        applyStimulus(1'b1, 1'b0, BASE + 64'h10, 64'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
        checkOutput("b2b rd rvalid", 64'(mm_rvalid), 64'd1);
        checkOutput("b2b rd rdata", mm_rdata, 64'hDEAD_BEEF_CAFE_F00D);
        checkOutput("b2b ready T2", 64'(mm_ready), 64'd1);
        tick();
        checkOutput("b2b idle rvalid", 64'(mm_rvalid), 64'd0);
        checkOutput("b2b idle rdata", mm_rdata, 64'd0);
`endif

        // Upper write-data bits beyond wlen must be ignored.
        doRequest("mask wr", 1'b0, 1'b1, BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FF5A, 4'd1, 1'b0, 1'b0, 64'd0);
        doRequest("mask rd", 1'b1, 1'b0, BASE + 64'h10, 64'd0, 4'd0, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F05A);
        tick();

`ifdef DMEM_WAIT_EN
        // Stall profile: accept at T, second request held through the stall.
        applyStimulus(1'b1, 1'b0, BASE, 64'd0, 4'd0);
        tick();
        applyStimulus(1'b1, 1'b0, BASE + 64'h10, 64'd0, 4'd0);
        checkOutput("wait T1 ready", 64'(mm_ready), 64'd0);
        checkOutput("wait T1 rvalid", 64'(mm_rvalid), 64'd0);
        tick();
        checkOutput("wait T2 ready", 64'(mm_ready), 64'd0);
        checkOutput("wait T2 rvalid", 64'(mm_rvalid), 64'd0);
        tick();
        checkOutput("wait T3 ready", 64'(mm_ready), 64'd0);
        checkOutput("wait T3 rvalid", 64'(mm_rvalid), 64'd1);
        checkOutput("wait T3 rdata", mm_rdata, 64'hBEEF_3344_AB66_7788);
        tick();
        checkOutput("wait T4 ready", 64'(mm_ready), 64'd1);
        checkOutput("wait T4 rvalid", 64'(mm_rvalid), 64'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
        checkOutput("held T5 ready", 64'(mm_ready), 64'd0);
        tick();
        checkOutput("held T6 rvalid", 64'(mm_rvalid), 64'd0);
        tick();
        checkOutput("held T7 rvalid", 64'(mm_rvalid), 64'd1);
        checkOutput("held T7 rdata", mm_rdata, 64'hDEAD_BEEF_CAFE_F05A);
        tick();

        // Reset while a request sits in WAIT: its response must never appear.
        applyStimulus(1'b1, 1'b0, BASE, 64'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            saw_valid = saw_valid | mm_rvalid;
            tick();
        end
        checkOutput("rst wait no rvalid", 64'(saw_valid), 64'd0);
        checkOutput("rst wait ready", 64'(mm_ready), 64'd1);
`else
        // A request presented together with reset is dropped.
        rstn = 1'b0;
        applyStimulus(1'b1, 1'b0, BASE, 64'd0, 4'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 64'd0, 64'd0, 4'd0);
        rstn = 1'b1;
        saw_valid = mm_rvalid;
        tick();
        saw_valid = saw_valid | mm_rvalid;
        checkOutput("rst req no rvalid", 64'(saw_valid), 64'd0);
        checkOutput("rst req ready", 64'(mm_ready), 64'd1);
`endif

        // RAM contents survive reset.
        doRequest("post rst rd", 1'b1, 1'b0, BASE, 64'd0, 4'd0, 1'b0, 1'b1, 64'hBEEF_3344_AB66_7788);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
